aes_sbox: RTL and testbench

//   AES-128 forward SubBytes substitution box (FIPS-197 Fig. 7). Maps an 8-bit

---
 rtl/aes_pkg.sv | 269 ++++++++++++++++++++++++++
 rtl/aes_sbox.sv | 49 ++++
 tb/tb_aes_sbox.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and the forward S-box lookup (FIPS-197 SubBytes table).
// The table lives here once so the round datapath and key expansion stay in sync.
package aes_pkg;

    localparam logic [7:0] AES_SBOX_RESET = 8'h63;

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        sbox_f = AES_SBOX_RESET;
        case (a)
            8'h00: sbox_f = 8'h63;
            8'h01: sbox_f = 8'h7c;
            8'h02: sbox_f = 8'h77;
            8'h03: sbox_f = 8'h7b;
            8'h04: sbox_f = 8'hf2;
            8'h05: sbox_f = 8'h6b;
            8'h06: sbox_f = 8'h6f;
            8'h07: sbox_f = 8'hc5;
            8'h08: sbox_f = 8'h30;
            8'h09: sbox_f = 8'h01;
            8'h0a: sbox_f = 8'h67;
            8'h0b: sbox_f = 8'h2b;
            8'h0c: sbox_f = 8'hfe;
            8'h0d: sbox_f = 8'hd7;
            8'h0e: sbox_f = 8'hab;
            8'h0f: sbox_f = 8'h76;
            8'h10: sbox_f = 8'hca;
            8'h11: sbox_f = 8'h82;
            8'h12: sbox_f = 8'hc9;
            8'h13: sbox_f = 8'h7d;
            8'h14: sbox_f = 8'hfa;
            8'h15: sbox_f = 8'h59;
            8'h16: sbox_f = 8'h47;
            8'h17: sbox_f = 8'hf0;
            8'h18: sbox_f = 8'had;
            8'h19: sbox_f = 8'hd4;
            8'h1a: sbox_f = 8'ha2;
            8'h1b: sbox_f = 8'haf;
            8'h1c: sbox_f = 8'h9c;
            8'h1d: sbox_f = 8'ha4;
            8'h1e: sbox_f = 8'h72;
            8'h1f: sbox_f = 8'hc0;
            8'h20: sbox_f = 8'hb7;
            8'h21: sbox_f = 8'hfd;
            8'h22: sbox_f = 8'h93;
            8'h23: sbox_f = 8'h26;
            8'h24: sbox_f = 8'h36;
            8'h25: sbox_f = 8'h3f;
            8'h26: sbox_f = 8'hf7;
            8'h27: sbox_f = 8'hcc;
            8'h28: sbox_f = 8'h34;
            8'h29: sbox_f = 8'ha5;
            8'h2a: sbox_f = 8'he5;
            8'h2b: sbox_f = 8'hf1;
            8'h2c: sbox_f = 8'h71;
            8'h2d: sbox_f = 8'hd8;
            8'h2e: sbox_f = 8'h31;
            8'h2f: sbox_f = 8'h15;
            8'h30: sbox_f = 8'h04;
            8'h31: sbox_f = 8'hc7;
            8'h32: sbox_f = 8'h23;
            8'h33: sbox_f = 8'hc3;
            8'h34: sbox_f = 8'h18;
            8'h35: sbox_f = 8'h96;
            8'h36: sbox_f = 8'h05;
            8'h37: sbox_f = 8'h9a;
            8'h38: sbox_f = 8'h07;
            8'h39: sbox_f = 8'h12;
            8'h3a: sbox_f = 8'h80;
            8'h3b: sbox_f = 8'he2;
            8'h3c: sbox_f = 8'heb;
            8'h3d: sbox_f = 8'h27;
            8'h3e: sbox_f = 8'hb2;
            8'h3f: sbox_f = 8'h75;
            8'h40: sbox_f = 8'h09;
            8'h41: sbox_f = 8'h83;
            8'h42: sbox_f = 8'h2c;
            8'h43: sbox_f = 8'h1a;
            8'h44: sbox_f = 8'h1b;
            8'h45: sbox_f = 8'h6e;
            8'h46: sbox_f = 8'h5a;
            8'h47: sbox_f = 8'ha0;
            8'h48: sbox_f = 8'h52;
            8'h49: sbox_f = 8'h3b;
            8'h4a: sbox_f = 8'hd6;
            8'h4b: sbox_f = 8'hb3;
            8'h4c: sbox_f = 8'h29;
            8'h4d: sbox_f = 8'he3;
            8'h4e: sbox_f = 8'h2f;
            8'h4f: sbox_f = 8'h84;
            8'h50: sbox_f = 8'h53;
            8'h51: sbox_f = 8'hd1;
            8'h52: sbox_f = 8'h00;
            8'h53: sbox_f = 8'hed;
            8'h54: sbox_f = 8'h20;
            8'h55: sbox_f = 8'hfc;
            8'h56: sbox_f = 8'hb1;
            8'h57: sbox_f = 8'h5b;
            8'h58: sbox_f = 8'h6a;
            8'h59: sbox_f = 8'hcb;
            8'h5a: sbox_f = 8'hbe;
            8'h5b: sbox_f = 8'h39;
            8'h5c: sbox_f = 8'h4a;
            8'h5d: sbox_f = 8'h4c;
            8'h5e: sbox_f = 8'h58;
            8'h5f: sbox_f = 8'hcf;
            8'h60: sbox_f = 8'hd0;
            8'h61: sbox_f = 8'hef;
            8'h62: sbox_f = 8'haa;
            8'h63: sbox_f = 8'hfb;
            8'h64: sbox_f = 8'h43;
            8'h65: sbox_f = 8'h4d;
            8'h66: sbox_f = 8'h33;
            8'h67: sbox_f = 8'h85;
            8'h68: sbox_f = 8'h45;
            8'h69: sbox_f = 8'hf9;
            8'h6a: sbox_f = 8'h02;
            8'h6b: sbox_f = 8'h7f;
            8'h6c: sbox_f = 8'h50;
            8'h6d: sbox_f = 8'h3c;
            8'h6e: sbox_f = 8'h9f;
            8'h6f: sbox_f = 8'ha8;
            8'h70: sbox_f = 8'h51;
            8'h71: sbox_f = 8'ha3;
            8'h72: sbox_f = 8'h40;
            8'h73: sbox_f = 8'h8f;
            8'h74: sbox_f = 8'h92;
            8'h75: sbox_f = 8'h9d;
            8'h76: sbox_f = 8'h38;
            8'h77: sbox_f = 8'hf5;
            8'h78: sbox_f = 8'hbc;
            8'h79: sbox_f = 8'hb6;
            8'h7a: sbox_f = 8'hda;
            8'h7b: sbox_f = 8'h21;
            8'h7c: sbox_f = 8'h10;
            8'h7d: sbox_f = 8'hff;
            8'h7e: sbox_f = 8'hf3;
            8'h7f: sbox_f = 8'hd2;
            8'h80: sbox_f = 8'hcd;
            8'h81: sbox_f = 8'h0c;
            8'h82: sbox_f = 8'h13;
            8'h83: sbox_f = 8'hec;
            8'h84: sbox_f = 8'h5f;
            8'h85: sbox_f = 8'h97;
            8'h86: sbox_f = 8'h44;
            8'h87: sbox_f = 8'h17;
            8'h88: sbox_f = 8'hc4;
            8'h89: sbox_f = 8'ha7;
            8'h8a: sbox_f = 8'h7e;
            8'h8b: sbox_f = 8'h3d;
            8'h8c: sbox_f = 8'h64;
            8'h8d: sbox_f = 8'h5d;
            8'h8e: sbox_f = 8'h19;
            8'h8f: sbox_f = 8'h73;
            8'h90: sbox_f = 8'h60;
            8'h91: sbox_f = 8'h81;
            8'h92: sbox_f = 8'h4f;
            8'h93: sbox_f = 8'hdc;
            8'h94: sbox_f = 8'h22;
            8'h95: sbox_f = 8'h2a;
            8'h96: sbox_f = 8'h90;
            8'h97: sbox_f = 8'h88;
            8'h98: sbox_f = 8'h46;
            8'h99: sbox_f = 8'hee;
            8'h9a: sbox_f = 8'hb8;
            8'h9b: sbox_f = 8'h14;
            8'h9c: sbox_f = 8'hde;
            8'h9d: sbox_f = 8'h5e;
            8'h9e: sbox_f = 8'h0b;
            8'h9f: sbox_f = 8'hdb;
            8'ha0: sbox_f = 8'he0;
            8'ha1: sbox_f = 8'h32;
            8'ha2: sbox_f = 8'h3a;
            8'ha3: sbox_f = 8'h0a;
            8'ha4: sbox_f = 8'h49;
            8'ha5: sbox_f = 8'h06;
            8'ha6: sbox_f = 8'h24;
            8'ha7: sbox_f = 8'h5c;
            8'ha8: sbox_f = 8'hc2;
            8'ha9: sbox_f = 8'hd3;
            8'haa: sbox_f = 8'hac;
            8'hab: sbox_f = 8'h62;
            8'hac: sbox_f = 8'h91;
            8'had: sbox_f = 8'h95;
            8'hae: sbox_f = 8'he4;
            8'haf: sbox_f = 8'h79;
            8'hb0: sbox_f = 8'he7;
            8'hb1: sbox_f = 8'hc8;
            8'hb2: sbox_f = 8'h37;
            8'hb3: sbox_f = 8'h6d;
            8'hb4: sbox_f = 8'h8d;
            8'hb5: sbox_f = 8'hd5;
            8'hb6: sbox_f = 8'h4e;
            8'hb7: sbox_f = 8'ha9;
            8'hb8: sbox_f = 8'h6c;
            8'hb9: sbox_f = 8'h56;
            8'hba: sbox_f = 8'hf4;
            8'hbb: sbox_f = 8'hea;
            8'hbc: sbox_f = 8'h65;
            8'hbd: sbox_f = 8'h7a;
            8'hbe: sbox_f = 8'hae;
            8'hbf: sbox_f = 8'h08;
            8'hc0: sbox_f = 8'hba;
            8'hc1: sbox_f = 8'h78;
            8'hc2: sbox_f = 8'h25;
            8'hc3: sbox_f = 8'h2e;
            8'hc4: sbox_f = 8'h1c;
            8'hc5: sbox_f = 8'ha6;
            8'hc6: sbox_f = 8'hb4;
            8'hc7: sbox_f = 8'hc6;
            8'hc8: sbox_f = 8'he8;
            8'hc9: sbox_f = 8'hdd;
            8'hca: sbox_f = 8'h74;
            8'hcb: sbox_f = 8'h1f;
            8'hcc: sbox_f = 8'h4b;
            8'hcd: sbox_f = 8'hbd;
            8'hce: sbox_f = 8'h8b;
            8'hcf: sbox_f = 8'h8a;
            8'hd0: sbox_f = 8'h70;
            8'hd1: sbox_f = 8'h3e;
            8'hd2: sbox_f = 8'hb5;
            8'hd3: sbox_f = 8'h66;
            8'hd4: sbox_f = 8'h48;
            8'hd5: sbox_f = 8'h03;
            8'hd6: sbox_f = 8'hf6;
            8'hd7: sbox_f = 8'h0e;
            8'hd8: sbox_f = 8'h61;
            8'hd9: sbox_f = 8'h35;
            8'hda: sbox_f = 8'h57;
            8'hdb: sbox_f = 8'hb9;
            8'hdc: sbox_f = 8'h86;
            8'hdd: sbox_f = 8'hc1;
            8'hde: sbox_f = 8'h1d;
            8'hdf: sbox_f = 8'h9e;
            8'he0: sbox_f = 8'he1;
            8'he1: sbox_f = 8'hf8;
            8'he2: sbox_f = 8'h98;
            8'he3: sbox_f = 8'h11;
            8'he4: sbox_f = 8'h69;
            8'he5: sbox_f = 8'hd9;
            8'he6: sbox_f = 8'h8e;
            8'he7: sbox_f = 8'h94;
            8'he8: sbox_f = 8'h9b;
            8'he9: sbox_f = 8'h1e;
            8'hea: sbox_f = 8'h87;
            8'heb: sbox_f = 8'he9;
            8'hec: sbox_f = 8'hce;
            8'hed: sbox_f = 8'h55;
            8'hee: sbox_f = 8'h28;
            8'hef: sbox_f = 8'hdf;
            8'hf0: sbox_f = 8'h8c;
            8'hf1: sbox_f = 8'ha1;
            8'hf2: sbox_f = 8'h89;
            8'hf3: sbox_f = 8'h0d;
            8'hf4: sbox_f = 8'hbf;
            8'hf5: sbox_f = 8'he6;
            8'hf6: sbox_f = 8'h42;
            8'hf7: sbox_f = 8'h68;
            8'hf8: sbox_f = 8'h41;
            8'hf9: sbox_f = 8'h99;
            8'hfa: sbox_f = 8'h2d;
            8'hfb: sbox_f = 8'h0f;
            8'hfc: sbox_f = 8'hb0;
            8'hfd: sbox_f = 8'h54;
            8'hfe: sbox_f = 8'hbb;
            8'hff: sbox_f = 8'h16;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box byte lane: combinational table lookup followed by one register stage.
// Optional registered even-parity output dout_par when AES_SBOX_PARITY_EN is defined.
module aes_sbox
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    output logic [7:0] dout
`ifdef AES_SBOX_PARITY_EN
    ,
    output logic       dout_par
`endif
);

    logic [7:0] w_sbox;
    logic [7:0] r_dout;

    assign w_sbox = sbox_f(addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= AES_SBOX_RESET;
        end else begin
            r_dout <= w_sbox;
        end
    end

    assign dout = r_dout;

`ifdef AES_SBOX_PARITY_EN
    // Parity is taken from the live table output so a corrupted lookup is visible downstream.
    logic w_par;
    logic r_dout_par;

    assign w_par = ^w_sbox;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_par <= ^AES_SBOX_RESET;
        end else begin
            r_dout_par <= w_par;
        end
    end

    assign dout_par = r_dout_par;
`endif

endmodule

// File: tb/tb_aes_sbox.sv
// Self-checking bench for aes_sbox: expected bytes come from literal spot values or an
// independent GF(2^8) inverse + affine model, queued at drive time and popped after the edge.
module tb_aes_sbox;

    logic       clk;
    logic       rst_n;
    logic [7:0] addr;
    logic [7:0] dout;
`ifdef AES_SBOX_PARITY_EN
    logic       doutPar;
`endif

    int checkCount = 0;
    int failCount  = 0;
    logic [7:0] expQ[$];

    aes_sbox dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .dout    (dout)
`ifdef AES_SBOX_PARITY_EN
        ,
        .dout_par(doutPar)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends even if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // S(x) = affine(x^-1) over GF(2^8) with 0 mapping to 0 before the affine step.
    function automatic logic [7:0] sboxModel(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        inv = 8'h00;
        c   = 8'h63;
        if (x != 8'h00) begin
            for (int i = 1; i < 256; i++) begin
                if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                 ^ inv[(i + 7) % 8] ^ c[i];
        end
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %02h expected %02h", tag, observed, expected);
        end
    endtask

    // Drive one byte, queue its expected result, then compare after the next rising edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] expected, input string tag);
        logic [7:0] exp;
        addr = a;
        expQ.push_back(expected);
        @(posedge clk);
        #1;
        exp = expQ.pop_front();
        checkOutput(tag, dout, exp);
`ifdef AES_SBOX_PARITY_EN
        checkOutput({tag, "_par"}, {7'd0, doutPar}, {7'd0, ^exp});
`endif
    endtask

    logic [7:0] spotAddr[6] = '{8'h00, 8'h01, 8'h10, 8'h53, 8'h80, 8'hff};
    logic [7:0] spotExp[6]  = '{8'h63, 8'h7c, 8'hca, 8'hed, 8'hcd, 8'h16};
    logic [7:0] b2bAddr[4]  = '{8'hff, 8'h00, 8'h53, 8'h01};
    logic [7:0] b2bExp[4]   = '{8'h16, 8'h63, 8'hed, 8'h7c};

    initial begin
        rst_n = 1'b0;
        addr  = 8'h00;

        // Reset holds dout at 63 across edges while addr toggles.
        for (int i = 0; i < 4; i++) begin
            addr = 8'(8'h35 * (i + 1));
            @(posedge clk);
            #1;
            checkOutput("reset_hold", dout, 8'h63);
`ifdef AES_SBOX_PARITY_EN
            checkOutput("reset_par", {7'd0, doutPar}, 8'h00);
`endif
        end
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(spotAddr[i], spotExp[i], $sformatf("spot_%02h", spotAddr[i]));
        end

        for (int i = 255; i >= 0; i--) begin
            applyStimulus(8'(i), sboxModel(8'(i)), $sformatf("sweep_%02h", i));
            if (i == 128) begin
                // Asynchronous reset between edges while addr=53.
                addr = 8'h53;
                #1;
                rst_n = 1'b0;
                #1;
                checkOutput("async_reset", dout, 8'h63);
`ifdef AES_SBOX_PARITY_EN
                checkOutput("async_reset_par", {7'd0, doutPar}, 8'h00);
`endif
                #1;
                rst_n = 1'b1;
                applyStimulus(8'h53, 8'hed, "post_reset");
            end
        end

        for (int i = 0; i < 4; i++) begin
            applyStimulus(b2bAddr[i], b2bExp[i], $sformatf("b2b_%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
